// File: rtl/rs_dispatch_arbiter_if.sv
// Bundle of signals between the reservation-station banks and the dispatch arbiter.
// master : RS/exec side (drives requests, stall and flush; receives clears and the dispatch slot)
// slave  : arbiter side
//   add_req/mul_req : per-entry ready requests from the add/sub and mul/div banks
//   cdb_stall       : exec/CDB cannot accept an op this cycle
//   flush           : synchronous squash
//   add_clr/mul_clr : one-hot entry-clear strobes back to the banks (combinational)
//   disp_valid/disp_unit/disp_idx : registered dispatch slot
//   mul_busy        : registered mul/div occupancy flag
interface rs_dispatch_arbiter_if #(
    parameter int ADD_ENTRIES = 3,
    parameter int MUL_ENTRIES = 3,
    parameter int IDX_W       = 2
);
    logic [ADD_ENTRIES-1:0] add_req;
    logic [MUL_ENTRIES-1:0] mul_req;
    logic                   cdb_stall;
    logic                   flush;
    logic [ADD_ENTRIES-1:0] add_clr;
    logic [MUL_ENTRIES-1:0] mul_clr;
    logic                   disp_valid;
    logic                   disp_unit;
    logic [IDX_W-1:0]       disp_idx;
    logic                   mul_busy;

    modport master (
        output add_req, mul_req, cdb_stall, flush,
        input  add_clr, mul_clr, disp_valid, disp_unit, disp_idx, mul_busy
    );

    modport slave (
        input  add_req, mul_req, cdb_stall, flush,
        output add_clr, mul_clr, disp_valid, disp_unit, disp_idx, mul_busy
    );
endinterface

// File: rtl/rs_dispatch_arbiter.sv
// Dispatch arbiter: picks at most one ready RS entry per cycle from the add/sub and
// mul/div banks, drives the single dispatch slot, tracks mul/div unit occupancy and
// strobes the entry-clear back to the owning bank.
// Ports:
//   clk1  : clock, rising edge
//   rst_n : asynchronous active-low reset
//   rs    : rs_dispatch_arbiter_if.slave (requests, stall, flush, clears, dispatch slot)
// Optional build macro RS_DISPATCH_STATS_EN adds three 16-bit saturating counters:
//   stat_add_grants, stat_mul_grants, stat_stall_cycles (cleared by rst_n only).
module rs_dispatch_arbiter #(
    parameter int ADD_ENTRIES = 3,
    parameter int MUL_ENTRIES = 3,
    parameter int IDX_W       = 2,
    parameter int MUL_LAT     = 4
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    rs_dispatch_arbiter_if.slave  rs
`ifdef RS_DISPATCH_STATS_EN
    ,
    output logic [15:0]           stat_add_grants,
    output logic [15:0]           stat_mul_grants,
    output logic [15:0]           stat_stall_cycles
`endif
);

    logic             disp_valid_q, disp_valid_d;
    logic             disp_unit_q,  disp_unit_d;
    logic [IDX_W-1:0] disp_idx_q,   disp_idx_d;
    logic             mul_busy_q,   mul_busy_d;
    logic [3:0]       mul_cnt_q,    mul_cnt_d;
    logic [IDX_W-1:0] add_ptr_q,    add_ptr_d;
    logic [IDX_W-1:0] mul_ptr_q,    mul_ptr_d;
    logic             last_unit_q,  last_unit_d;

    logic             add_found, mul_found;
    logic [IDX_W-1:0] add_win,   mul_win;
    logic             add_ok,    mul_ok;
    logic             grant_add, grant_mul;
    logic [ADD_ENTRIES-1:0] add_clr_c;
    logic [MUL_ENTRIES-1:0] mul_clr_c;

    // Rotating-priority search: start at the pointer, wrap at the entry count.
    always_comb begin
        int j;
        add_found = 1'b0;
        add_win   = '0;
        for (int k = 0; k < ADD_ENTRIES; k++) begin
            j = int'(add_ptr_q) + k;
            if (j >= ADD_ENTRIES) j = j - ADD_ENTRIES;
            if (!add_found && rs.add_req[j]) begin
                add_found = 1'b1;
                add_win   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        int j;
        mul_found = 1'b0;
        mul_win   = '0;
        for (int k = 0; k < MUL_ENTRIES; k++) begin
            j = int'(mul_ptr_q) + k;
            if (j >= MUL_ENTRIES) j = j - MUL_ENTRIES;
            if (!mul_found && rs.mul_req[j]) begin
                mul_found = 1'b1;
                mul_win   = IDX_W'(j);
            end
        end
    end

    // Under contention the bank that did not win last time goes; last_unit resets to
    // the mul bank so the add bank takes the first tie.
    always_comb begin
        add_ok    = add_found & ~rs.cdb_stall & ~rs.flush;
        mul_ok    = mul_found & (mul_cnt_q == 4'd0) & ~rs.cdb_stall & ~rs.flush;
        grant_add = add_ok & (~mul_ok | last_unit_q);
        grant_mul = mul_ok & (~add_ok | ~last_unit_q);
    end

    // Clears are gated by rst_n so nothing strobes while reset is held.
    always_comb begin
        add_clr_c = '0;
        mul_clr_c = '0;
        if (rst_n && grant_add) add_clr_c[add_win] = 1'b1;
        if (rst_n && grant_mul) mul_clr_c[mul_win] = 1'b1;
    end

    always_comb begin
        disp_valid_d = grant_add | grant_mul;
        disp_unit_d  = disp_unit_q;
        disp_idx_d   = disp_idx_q;
        add_ptr_d    = add_ptr_q;
        mul_ptr_d    = mul_ptr_q;
        last_unit_d  = last_unit_q;
        mul_cnt_d    = (mul_cnt_q != 4'd0) ? mul_cnt_q - 4'd1 : 4'd0;

        if (grant_add) begin
            disp_unit_d = 1'b0;
            disp_idx_d  = add_win;
            last_unit_d = 1'b0;
            add_ptr_d   = (add_win == IDX_W'(ADD_ENTRIES - 1)) ? '0 : add_win + 1'b1;
        end else if (grant_mul) begin
            disp_unit_d = 1'b1;
            disp_idx_d  = mul_win;
            last_unit_d = 1'b1;
            mul_ptr_d   = (mul_win == IDX_W'(MUL_ENTRIES - 1)) ? '0 : mul_win + 1'b1;
            mul_cnt_d   = 4'(MUL_LAT - 1);
        end

        if (rs.flush) begin
            mul_cnt_d   = 4'd0;
            add_ptr_d   = '0;
            mul_ptr_d   = '0;
            last_unit_d = 1'b1;
        end

        mul_busy_d = (mul_cnt_d != 4'd0);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid_q <= 1'b0;
            disp_unit_q  <= 1'b0;
            disp_idx_q   <= '0;
            mul_busy_q   <= 1'b0;
            mul_cnt_q    <= 4'd0;
            add_ptr_q    <= '0;
            mul_ptr_q    <= '0;
            last_unit_q  <= 1'b1;
        end else begin
            disp_valid_q <= disp_valid_d;
            disp_unit_q  <= disp_unit_d;
            disp_idx_q   <= disp_idx_d;
            mul_busy_q   <= mul_busy_d;
            mul_cnt_q    <= mul_cnt_d;
            add_ptr_q    <= add_ptr_d;
            mul_ptr_q    <= mul_ptr_d;
            last_unit_q  <= last_unit_d;
        end
    end

    assign rs.add_clr    = add_clr_c;
    assign rs.mul_clr    = mul_clr_c;
    assign rs.disp_valid = disp_valid_q;
    assign rs.disp_unit  = disp_unit_q;
    assign rs.disp_idx   = disp_idx_q;
    assign rs.mul_busy   = mul_busy_q;

`ifdef RS_DISPATCH_STATS_EN
    logic [15:0] stat_add_q,   stat_add_d;
    logic [15:0] stat_mul_q,   stat_mul_d;
    logic [15:0] stat_stall_q, stat_stall_d;
    logic        any_req;

    always_comb begin
        any_req      = (|rs.add_req) | (|rs.mul_req);
        stat_add_d   = stat_add_q;
        stat_mul_d   = stat_mul_q;
        stat_stall_d = stat_stall_q;
        if (grant_add && stat_add_q != 16'hFFFF) stat_add_d = stat_add_q + 16'd1;
        if (grant_mul && stat_mul_q != 16'hFFFF) stat_mul_d = stat_mul_q + 16'd1;
        if (any_req && !grant_add && !grant_mul && stat_stall_q != 16'hFFFF)
            stat_stall_d = stat_stall_q + 16'd1;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stat_add_q   <= 16'd0;
            stat_mul_q   <= 16'd0;
            stat_stall_q <= 16'd0;
        end else begin
            stat_add_q   <= stat_add_d;
            stat_mul_q   <= stat_mul_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_add_grants   = stat_add_q;
    assign stat_mul_grants   = stat_mul_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_rs_dispatch_arbiter.sv
// Directed bench for rs_dispatch_arbiter (ADD/MUL entries 3, IDX_W 2, MUL_LAT 4).
// Inputs change 1 time unit after a rising edge; clears are sampled 1 unit later,
// registered outputs 1 unit after the following rising edge.
module tb_rs_dispatch_arbiter;
    logic clk1;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    rs_dispatch_arbiter_if #(.ADD_ENTRIES(3), .MUL_ENTRIES(3), .IDX_W(2)) rs_bus ();

`ifdef RS_DISPATCH_STATS_EN
    logic [15:0] stat_add_grants, stat_mul_grants, stat_stall_cycles;
`endif

    rs_dispatch_arbiter #(.ADD_ENTRIES(3), .MUL_ENTRIES(3), .IDX_W(2), .MUL_LAT(4)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .rs    (rs_bus)
`ifdef RS_DISPATCH_STATS_EN
        ,
        .stat_add_grants   (stat_add_grants),
        .stat_mul_grants   (stat_mul_grants),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic clear_inputs();
        rs_bus.add_req   = '0;
        rs_bus.mul_req   = '0;
        rs_bus.cdb_stall = 1'b0;
        rs_bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk1);
        @(posedge clk1);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rs_bus.mul_req = 3'b001;
        @(posedge clk1); #1;
        // reset asserted mid-operation with requests present
        rs_bus.mul_req = 3'b111;
        rs_bus.add_req = 3'b111;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rs_bus.add_clr !== 3'b000) $display("FAIL rst_add_clr: got %b expected 000", rs_bus.add_clr); else n_pass++;
        n_checks++; if (rs_bus.mul_clr !== 3'b000) $display("FAIL rst_mul_clr: got %b expected 000", rs_bus.mul_clr); else n_pass++;
        n_checks++; if (rs_bus.disp_valid !== 1'b0) $display("FAIL rst_disp_valid: got %b expected 0", rs_bus.disp_valid); else n_pass++;
        n_checks++; if (rs_bus.disp_unit !== 1'b0) $display("FAIL rst_disp_unit: got %b expected 0", rs_bus.disp_unit); else n_pass++;
        n_checks++; if (rs_bus.disp_idx !== 2'd0) $display("FAIL rst_disp_idx: got %0d expected 0", rs_bus.disp_idx); else n_pass++;
        n_checks++; if (rs_bus.mul_busy !== 1'b0) $display("FAIL rst_mul_busy: got %b expected 0", rs_bus.mul_busy); else n_pass++;
        clear_inputs();
        @(posedge clk1); #1;
        rst_n = 1'b1;
        #1;
        n_checks++; if (rs_bus.add_clr !== 3'b000) $display("FAIL rst_release_clr: got %b expected 000", rs_bus.add_clr); else n_pass++;
        @(posedge clk1); #1;
    endtask

    task automatic test_add_rotation();
        logic [2:0] req_v [4] = '{3'b111, 3'b110, 3'b100, 3'b000};
        logic [2:0] clr_v [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
        logic       vld_v [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] idx_v [3] = '{2'd0, 2'd1, 2'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rs_bus.add_req = req_v[i];
            #1;
            n_checks++; if (rs_bus.add_clr !== clr_v[i]) $display("FAIL rot_add_clr[%0d]: got %b expected %b", i, rs_bus.add_clr, clr_v[i]); else n_pass++;
            @(posedge clk1); #1;
            n_checks++; if (rs_bus.disp_valid !== vld_v[i]) $display("FAIL rot_valid[%0d]: got %b expected %b", i, rs_bus.disp_valid, vld_v[i]); else n_pass++;
            if (i < 3) begin
                n_checks++; if (rs_bus.disp_idx !== idx_v[i]) $display("FAIL rot_idx[%0d]: got %0d expected %0d", i, rs_bus.disp_idx, idx_v[i]); else n_pass++;
                n_checks++; if (rs_bus.disp_unit !== 1'b0) $display("FAIL rot_unit[%0d]: got %b expected 0", i, rs_bus.disp_unit); else n_pass++;
            end
        end
    endtask

    task automatic test_alternation();
        logic [2:0] aclr_v [6] = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
        logic [2:0] mclr_v [6] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
        logic       unit_v [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       busy_v [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        rs_bus.add_req = 3'b001;
        rs_bus.mul_req = 3'b001;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (rs_bus.add_clr !== aclr_v[i]) $display("FAIL alt_add_clr[%0d]: got %b expected %b", i, rs_bus.add_clr, aclr_v[i]); else n_pass++;
            n_checks++; if (rs_bus.mul_clr !== mclr_v[i]) $display("FAIL alt_mul_clr[%0d]: got %b expected %b", i, rs_bus.mul_clr, mclr_v[i]); else n_pass++;
            @(posedge clk1); #1;
            n_checks++; if (rs_bus.disp_unit !== unit_v[i]) $display("FAIL alt_unit[%0d]: got %b expected %b", i, rs_bus.disp_unit, unit_v[i]); else n_pass++;
            n_checks++; if (rs_bus.mul_busy !== busy_v[i]) $display("FAIL alt_busy[%0d]: got %b expected %b", i, rs_bus.mul_busy, busy_v[i]); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_mul_latency();
        logic [2:0] req_v  [5] = '{3'b011, 3'b010, 3'b010, 3'b010, 3'b010};
        logic [2:0] clr_v  [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010};
        logic       vld_v  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rs_bus.mul_req = req_v[i];
            #1;
            n_checks++; if (rs_bus.mul_clr !== clr_v[i]) $display("FAIL lat_mul_clr[%0d]: got %b expected %b", i, rs_bus.mul_clr, clr_v[i]); else n_pass++;
            @(posedge clk1); #1;
            n_checks++; if (rs_bus.disp_valid !== vld_v[i]) $display("FAIL lat_valid[%0d]: got %b expected %b", i, rs_bus.disp_valid, vld_v[i]); else n_pass++;
        end
        n_checks++; if (rs_bus.disp_idx !== 2'd1) $display("FAIL lat_idx: got %0d expected 1", rs_bus.disp_idx); else n_pass++;
        n_checks++; if (rs_bus.disp_unit !== 1'b1) $display("FAIL lat_unit: got %b expected 1", rs_bus.disp_unit); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_cdb_stall();
        do_reset();
        rs_bus.add_req   = 3'b010;
        rs_bus.cdb_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (rs_bus.add_clr !== 3'b000) $display("FAIL stall_clr[%0d]: got %b expected 000", i, rs_bus.add_clr); else n_pass++;
            @(posedge clk1); #1;
            n_checks++; if (rs_bus.disp_valid !== 1'b0) $display("FAIL stall_valid[%0d]: got %b expected 0", i, rs_bus.disp_valid); else n_pass++;
        end
        rs_bus.cdb_stall = 1'b0;
        #1;
        n_checks++; if (rs_bus.add_clr !== 3'b010) $display("FAIL stall_release_clr: got %b expected 010", rs_bus.add_clr); else n_pass++;
        @(posedge clk1); #1;
        n_checks++; if (rs_bus.disp_valid !== 1'b1) $display("FAIL stall_release_valid: got %b expected 1", rs_bus.disp_valid); else n_pass++;
        n_checks++; if (rs_bus.disp_idx !== 2'd1) $display("FAIL stall_release_idx: got %0d expected 1", rs_bus.disp_idx); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        rs_bus.mul_req = 3'b001;            // mul grant, mul_cnt -> 3, mul_ptr -> 1
        @(posedge clk1); #1;
        rs_bus.mul_req = 3'b000;            // mul_cnt -> 2
        @(posedge clk1); #1;
        rs_bus.add_req = 3'b001;
        rs_bus.mul_req = 3'b001;
        rs_bus.flush   = 1'b1;
        #1;
        n_checks++; if (rs_bus.add_clr !== 3'b000) $display("FAIL flush_add_clr: got %b expected 000", rs_bus.add_clr); else n_pass++;
        n_checks++; if (rs_bus.mul_clr !== 3'b000) $display("FAIL flush_mul_clr: got %b expected 000", rs_bus.mul_clr); else n_pass++;
        @(posedge clk1); #1;
        rs_bus.flush = 1'b0;
        n_checks++; if (rs_bus.disp_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", rs_bus.disp_valid); else n_pass++;
        n_checks++; if (rs_bus.mul_busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", rs_bus.mul_busy); else n_pass++;
        #1;
        n_checks++; if (rs_bus.add_clr !== 3'b001) $display("FAIL flush_next_add_clr: got %b expected 001", rs_bus.add_clr); else n_pass++;
        n_checks++; if (rs_bus.mul_clr !== 3'b000) $display("FAIL flush_next_mul_clr: got %b expected 000", rs_bus.mul_clr); else n_pass++;
        @(posedge clk1); #1;
        n_checks++; if (rs_bus.disp_unit !== 1'b0 || rs_bus.disp_idx !== 2'd0) $display("FAIL flush_next_slot: got unit %b idx %0d expected unit 0 idx 0", rs_bus.disp_unit, rs_bus.disp_idx); else n_pass++;
        rs_bus.mul_req = 3'b011;            // pointer was reset, entry 0 must win
        #1;
        n_checks++; if (rs_bus.mul_clr !== 3'b001) $display("FAIL flush_mul_elig: got %b expected 001", rs_bus.mul_clr); else n_pass++;
        @(posedge clk1); #1;
        n_checks++; if (rs_bus.disp_unit !== 1'b1 || rs_bus.mul_busy !== 1'b1) $display("FAIL flush_mul_slot: got unit %b busy %b expected unit 1 busy 1", rs_bus.disp_unit, rs_bus.mul_busy); else n_pass++;
        clear_inputs();
    endtask

`ifdef RS_DISPATCH_STATS_EN
    task automatic test_stats();
        do_reset();
        rs_bus.add_req = 3'b001;
        repeat (5) @(posedge clk1);
        #1;
        rs_bus.add_req = 3'b000;
        rs_bus.mul_req = 3'b001;
        repeat (5) @(posedge clk1);         // grant, 3 busy stall cycles, grant
        #1;
        clear_inputs();
        @(posedge clk1); #1;
        n_checks++; if (stat_add_grants !== 16'd5) $display("FAIL stat_add: got %0d expected 5", stat_add_grants); else n_pass++;
        n_checks++; if (stat_mul_grants !== 16'd2) $display("FAIL stat_mul: got %0d expected 2", stat_mul_grants); else n_pass++;
        n_checks++; if (stat_stall_cycles !== 16'd3) $display("FAIL stat_stall: got %0d expected 3", stat_stall_cycles); else n_pass++;
        rs_bus.add_req = 3'b001;
        repeat (70000) @(posedge clk1);
        #1;
        clear_inputs();
        n_checks++; if (stat_add_grants !== 16'hFFFF) $display("FAIL stat_add_sat: got %h expected ffff", stat_add_grants); else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_add_rotation();
        test_alternation();
        test_mul_latency();
        test_cdb_stall();
        test_flush();
`ifdef RS_DISPATCH_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
